hdp_reg_sequencer: RTL and testbench



---
 rtl/hdp_reg_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_hdp_reg_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdp_reg_sequencer.sv
// hdp_reg_sequencer: walks a register-initialisation table held in an external
// synchronous ROM and issues one 16-bit SPI write per entry. Each transfer is
// paced off the SPI master's completion pulse, with a timeout guard.
// Optional read-back verification is enabled by defining HDP_SEQ_VERIFY_EN.
module hdp_reg_sequencer #(
    parameter int WORD_WIDTH     = 8,
    parameter int NUM_REGS       = 16,
    parameter int GAP_CYCLES     = 66,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [7:0]              o_err_index,
    output logic [7:0]              o_rom_addr,
    input  logic [2*WORD_WIDTH-1:0] i_rom_data,
    output logic                    o_spi_start,
    output logic [WORD_WIDTH-1:0]   o_tx_upper,
    output logic [WORD_WIDTH-1:0]   o_tx_lower,
    input  logic                    i_spi_complete,
    input  logic [WORD_WIDTH-1:0]   i_rx_lower
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  LAST_INDEX   = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_NEXT,
        S_DONE,
        S_ERROR
`ifdef HDP_SEQ_VERIFY_EN
        ,
        S_VERIFY,
        S_VWAIT,
        S_VGAP,
        S_CHECK
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              index_q, index_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]   tx_upper_q, tx_upper_d;
    logic [WORD_WIDTH-1:0]   tx_lower_q, tx_lower_d;
    logic                    spi_start_q, spi_start_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [7:0]              err_index_q, err_index_d;
`ifdef HDP_SEQ_VERIFY_EN
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]   rx_q, rx_d;
    // The top address bit is replaced by the read/write flag, so it is never consumed.
    logic                    unused_rom_msb;
    assign unused_rom_msb = i_rom_data[2*WORD_WIDTH-1];
`else
    // Address MSB is forced to the write flag and read-back data has no consumer here.
    logic                    unused_inputs;
    assign unused_inputs = ^{i_rom_data[2*WORD_WIDTH-1], i_rx_lower};
`endif

    // Next-state and registered-output computation for the sequencer.
    // Strobe, done and error flags are computed on the transition into the state
    // that owns them, so the registered copy is visible during that state.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        tx_upper_d  = tx_upper_q;
        tx_lower_d  = tx_lower_q;
        spi_start_d = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;
        err_index_d = err_index_q;
`ifdef HDP_SEQ_VERIFY_EN
        wdata_d     = wdata_q;
        rx_d        = rx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    error_d = 1'b0;
                    index_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                tx_upper_d  = {1'b0, i_rom_data[2*WORD_WIDTH-2:WORD_WIDTH]};
                tx_lower_d  = i_rom_data[WORD_WIDTH-1:0];
                spi_start_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_spi_complete) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    error_d     = 1'b1;
                    err_index_d = index_q;
                    state_d     = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
`ifdef HDP_SEQ_VERIFY_EN
                    tx_upper_d  = {1'b1, tx_upper_q[WORD_WIDTH-2:0]};
                    tx_lower_d  = '0;
                    wdata_d     = tx_lower_q;
                    spi_start_d = 1'b1;
                    state_d     = S_VERIFY;
`else
                    state_d     = S_NEXT;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_NEXT: begin
                if (index_q == LAST_INDEX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
`ifdef HDP_SEQ_VERIFY_EN
            S_VERIFY: begin
                cnt_d   = '0;
                state_d = S_VWAIT;
            end
            S_VWAIT: begin
                if (i_spi_complete) begin
                    rx_d    = i_rx_lower;
                    cnt_d   = '0;
                    state_d = S_VGAP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    error_d     = 1'b1;
                    err_index_d = index_q;
                    state_d     = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_VGAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                if (rx_q == wdata_q) begin
                    state_d = S_NEXT;
                end else begin
                    error_d     = 1'b1;
                    err_index_d = index_q;
                    state_d     = S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            cnt_q       <= '0;
            tx_upper_q  <= '0;
            tx_lower_q  <= '0;
            spi_start_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
`ifdef HDP_SEQ_VERIFY_EN
            wdata_q     <= '0;
            rx_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            tx_upper_q  <= tx_upper_d;
            tx_lower_q  <= tx_lower_d;
            spi_start_q <= spi_start_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
`ifdef HDP_SEQ_VERIFY_EN
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
`endif
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_error     = error_q;
    assign o_err_index = err_index_q;
    assign o_rom_addr  = index_q;
    assign o_spi_start = spi_start_q;
    assign o_tx_upper  = tx_upper_q;
    assign o_tx_lower  = tx_lower_q;

endmodule

// File: tb/tb_hdp_reg_sequencer.sv
// Bench for hdp_reg_sequencer: synchronous ROM model, SPI master responder and a
// table-level reference model of the expected strobe sequence and outcome.
module tb_hdp_reg_sequencer;

    localparam int W = 8;
    localparam int N = 3;
    localparam int G = 66;
    localparam int T = 256;

    logic         clk = 1'b0;
    logic         i_reset, i_start, i_spi_complete;
    logic [15:0]  i_rom_data;
    logic [7:0]   i_rx_lower;
    logic         o_busy, o_done, o_error, o_spi_start;
    logic [7:0]   o_err_index, o_rom_addr, o_tx_upper, o_tx_lower;

    always #5 clk = ~clk;

    hdp_reg_sequencer #(
        .WORD_WIDTH(W), .NUM_REGS(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_index(o_err_index), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_spi_start(o_spi_start), .o_tx_upper(o_tx_upper), .o_tx_lower(o_tx_lower),
        .i_spi_complete(i_spi_complete), .i_rx_lower(i_rx_lower)
    );

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] up;
        logic [7:0] lo;
    } strobe_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cycle = 0;
    logic [15:0] rom [0:255];
    strobe_t    got[$];
    strobe_t    exp[$];
    int         done_log[$];
    int         err_rise;
    bit         exp_done;
    logic [7:0] exp_err;
    int         resp_delay = 10;
    int         drop_idx = -1;
    int         bad_idx = -1;
    logic [7:0] bad_val = 8'h00;
    bit         spurious_en = 1'b0;
    int         start_cyc;

    always @(posedge clk) cycle <= cycle + 1;

    // Responder: synchronous ROM, SPI master completion model and output monitor.
    logic [7:0] prev_addr, cur_addr;
    bit         pending, cur_drop, cur_read, err_prev;
    int         cd, sp_cd;
    initial begin
        i_spi_complete = 1'b0; i_rx_lower = '0; i_rom_data = '0;
        prev_addr = '0; pending = 0; sp_cd = 0; err_prev = 0; cd = 0;
        forever begin
            @(posedge clk); #1;
            i_rom_data = rom[prev_addr];
            prev_addr = o_rom_addr;
            i_spi_complete = 1'b0;
            if (o_done) done_log.push_back(cycle);
            if (o_error && !err_prev) err_rise = cycle;
            err_prev = o_error;
            if (i_reset) begin
                pending = 0; sp_cd = 0;
            end else begin
                if (sp_cd > 0) begin
                    sp_cd--;
                    if (sp_cd == 0) i_spi_complete = 1'b1;
                end
                if (o_spi_start) begin
                    got.push_back('{cycle, o_rom_addr, o_tx_upper, o_tx_lower});
                    pending = 1; cd = resp_delay;
                    cur_addr = o_rom_addr; cur_read = o_tx_upper[7];
                    cur_drop = !o_tx_upper[7] && (int'(o_rom_addr) == drop_idx);
                end else if (pending) begin
                    cd--;
                    if (cd == 0) begin
                        pending = 0;
                        if (!cur_drop) begin
                            i_spi_complete = 1'b1;
                            if (cur_read)
                                i_rx_lower = (int'(cur_addr) == bad_idx) ? bad_val : rom[cur_addr][7:0];
                            else
                                i_rx_lower = 8'($urandom);
                            if (spurious_en) sp_cd = 10;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time limit, required completion");
        $fatal(1);
    end

    // Reference model: each table entry is one write (address MSB cleared), plus a
    // read (MSB set, data 0) when verification is built; stops at the failing entry.
    task automatic model_run(input int fail_idx);
        strobe_t s;
        exp.delete(); exp_done = 1; exp_err = 8'h00;
        for (int i = 0; i < N; i++) begin
            s.cyc = 0; s.addr = 8'(i);
            s.up = rom[i][15:8] & 8'h7F; s.lo = rom[i][7:0];
            exp.push_back(s);
            if (i == fail_idx) begin exp_done = 0; exp_err = 8'(i); break; end
`ifdef HDP_SEQ_VERIFY_EN
            s.up = rom[i][15:8] | 8'h80; s.lo = 8'h00;
            exp.push_back(s);
            if (i == bad_idx && bad_val != rom[i][7:0]) begin exp_done = 0; exp_err = 8'(i); break; end
`endif
        end
    endtask

    task automatic run_seq(input int delay, output bit timed_out);
        got.delete(); done_log.delete(); err_rise = -1; resp_delay = delay;
        @(negedge clk); i_start = 1'b1; start_cyc = cycle;
        @(negedge clk); i_start = 1'b0;
        timed_out = 1;
        for (int k = 0; k < N * 2 * (T + G + 10) + 50; k++) begin
            if (!o_busy) begin timed_out = 0; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({o_busy, o_done, o_error, o_spi_start, o_err_index, o_rom_addr, o_tx_upper, o_tx_lower} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b start=%b eidx=%h addr=%h up=%h lo=%h, required all 0",
                     o_busy, o_done, o_error, o_spi_start, o_err_index, o_rom_addr, o_tx_upper, o_tx_lower);
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_writes();
        bit to;
        rom[0] = 16'h01AA; rom[1] = 16'h8255; rom[2] = 16'h030F;
        drop_idx = -1; bad_idx = -1;
        model_run(-1);
        run_seq(200, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_busy_timeout: busy stuck high, required idle"); end
        n_cmp++;
        if (got.size() != exp.size()) begin
            n_bad++; $display("FAIL basic_strobe_count: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            n_cmp++;
            if ({got[i].addr, got[i].up, got[i].lo} !== {exp[i].addr, exp[i].up, exp[i].lo}) begin
                n_bad++; $display("FAIL basic_strobe[%0d]: got addr=%h up=%h lo=%h, required addr=%h up=%h lo=%h",
                                  i, got[i].addr, got[i].up, got[i].lo, exp[i].addr, exp[i].up, exp[i].lo);
            end
        end
        if (got.size() > 0) begin
            n_cmp++;
            if (got[0].cyc != start_cyc + 3) begin
                n_bad++; $display("FAIL basic_first_strobe_latency: got %0d, required 3", got[0].cyc - start_cyc);
            end
        end
`ifndef HDP_SEQ_VERIFY_EN
        for (int i = 1; i < got.size(); i++) begin
            n_cmp++;
            if (got[i].cyc - got[i-1].cyc != 200 + 3 + G + 1) begin
                n_bad++; $display("FAIL basic_strobe_interval[%0d]: got %0d, required %0d",
                                  i, got[i].cyc - got[i-1].cyc, 200 + 3 + G + 1);
            end
        end
`endif
        n_cmp++;
        if (done_log.size() != 1) begin
            n_bad++; $display("FAIL basic_done_count: got %0d, required 1", done_log.size());
        end else if (got.size() > 0) begin
            int req;
            req = got[got.size()-1].cyc + 200 + G + 2;
`ifdef HDP_SEQ_VERIFY_EN
            req = req + 1;
`endif
            n_cmp++;
            if (done_log[0] != req) begin
                n_bad++; $display("FAIL basic_done_time: got %0d, required %0d", done_log[0], req);
            end
        end
        n_cmp++;
        if (o_error !== 1'b0) begin n_bad++; $display("FAIL basic_error_flag: got %b, required 0", o_error); end
    endtask

    task automatic test_timeout();
        bit to;
        drop_idx = 1; bad_idx = -1;
        model_run(1);
        run_seq(150, to);
        drop_idx = -1;
        n_cmp++; if (to) begin n_bad++; $display("FAIL timeout_busy: busy stuck high, required idle"); end
        n_cmp++;
        if (got.size() != exp.size()) begin
            n_bad++; $display("FAIL timeout_strobe_count: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            n_cmp++;
            if ({got[i].addr, got[i].up, got[i].lo} !== {exp[i].addr, exp[i].up, exp[i].lo}) begin
                n_bad++; $display("FAIL timeout_strobe[%0d]: got %h/%h/%h, required %h/%h/%h",
                                  i, got[i].addr, got[i].up, got[i].lo, exp[i].addr, exp[i].up, exp[i].lo);
            end
        end
        n_cmp++;
        if ({o_error, o_err_index} !== {1'b1, exp_err}) begin
            n_bad++; $display("FAIL timeout_error: got err=%b idx=%0d, required err=1 idx=%0d", o_error, o_err_index, exp_err);
        end
        n_cmp++;
        if (done_log.size() != 0) begin n_bad++; $display("FAIL timeout_done: got %0d pulses, required 0", done_log.size()); end
        if (got.size() > 0) begin
            n_cmp++;
            if (err_rise != got[got.size()-1].cyc + T + 1) begin
                n_bad++; $display("FAIL timeout_latency: got %0d, required %0d", err_rise - got[got.size()-1].cyc, T + 1);
            end
        end
    endtask

`ifdef HDP_SEQ_VERIFY_EN
    task automatic test_verify_mismatch();
        bit to;
        rom[0] = 16'h01AA; rom[1] = 16'h8255; rom[2] = 16'h030F;
        bad_idx = 2; bad_val = 8'h0E;
        model_run(-1);
        run_seq(120, to);
        bad_idx = -1;
        n_cmp++; if (to) begin n_bad++; $display("FAIL verify_busy: busy stuck high, required idle"); end
        n_cmp++;
        if (got.size() != 6) begin n_bad++; $display("FAIL verify_strobe_count: got %0d, required 6", got.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            n_cmp++;
            if ({got[i].addr, got[i].up, got[i].lo} !== {exp[i].addr, exp[i].up, exp[i].lo}) begin
                n_bad++; $display("FAIL verify_strobe[%0d]: got %h/%h/%h, required %h/%h/%h",
                                  i, got[i].addr, got[i].up, got[i].lo, exp[i].addr, exp[i].up, exp[i].lo);
            end
        end
        n_cmp++;
        if ({o_error, o_err_index} !== {1'b1, 8'd2}) begin
            n_bad++; $display("FAIL verify_error: got err=%b idx=%0d, required err=1 idx=2", o_error, o_err_index);
        end
        n_cmp++;
        if (done_log.size() != 0) begin n_bad++; $display("FAIL verify_done: got %0d, required 0", done_log.size()); end
    endtask
`endif

    task automatic test_reset_midway();
        bit to, seen;
        rom[0] = 16'h1122; rom[1] = 16'h3344; rom[2] = 16'h5566;
        got.delete(); resp_delay = 200; seen = 0;
        @(negedge clk); i_start = 1'b1; @(negedge clk); i_start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (got.size() > 0 && got[got.size()-1].addr == 8'd1 && !got[got.size()-1].up[7]) begin seen = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL midreset_reach_index1: not reached, required write strobe for index 1"); end
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_busy, o_done, o_error, o_spi_start, o_err_index, o_rom_addr, o_tx_upper, o_tx_lower} !== 36'h0) begin
            n_bad++; $display("FAIL midreset_outputs: got busy=%b addr=%h up=%h lo=%h, required all 0",
                              o_busy, o_rom_addr, o_tx_upper, o_tx_lower);
        end
        i_reset = 1'b0;
        model_run(-1);
        run_seq(40, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL midreset_busy: busy stuck high, required idle"); end
        n_cmp++;
        if (got.size() != exp.size()) begin
            n_bad++; $display("FAIL midreset_strobe_count: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            n_cmp++;
            if ({got[i].addr, got[i].up, got[i].lo} !== {exp[i].addr, exp[i].up, exp[i].lo}) begin
                n_bad++; $display("FAIL midreset_strobe[%0d]: got %h/%h/%h, required %h/%h/%h",
                                  i, got[i].addr, got[i].up, got[i].lo, exp[i].addr, exp[i].up, exp[i].lo);
            end
        end
        n_cmp++;
        if (done_log.size() != 1) begin n_bad++; $display("FAIL midreset_done: got %0d, required 1", done_log.size()); end
    endtask

    task automatic test_busy_ignore();
        bit to;
        for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
        model_run(-1);
        got.delete(); done_log.delete(); resp_delay = 90; spurious_en = 1;
        @(negedge clk); i_start = 1'b1; @(negedge clk);
        to = 1;
        for (int k = 0; k < 4000; k++) begin
            if (!o_busy) begin to = 0; break; end
            i_start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        i_start = 1'b0; spurious_en = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (to) begin n_bad++; $display("FAIL ignore_busy: busy stuck high, required idle"); end
        n_cmp++;
        if (got.size() != exp.size()) begin
            n_bad++; $display("FAIL ignore_strobe_count: got %0d, required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            n_cmp++;
            if ({got[i].addr, got[i].up, got[i].lo} !== {exp[i].addr, exp[i].up, exp[i].lo}) begin
                n_bad++; $display("FAIL ignore_strobe[%0d]: got %h/%h/%h, required %h/%h/%h",
                                  i, got[i].addr, got[i].up, got[i].lo, exp[i].addr, exp[i].up, exp[i].lo);
            end
        end
        n_cmp++;
        if (done_log.size() != 1 || o_error !== 1'b0) begin
            n_bad++; $display("FAIL ignore_outcome: got done=%0d err=%b, required done=1 err=0", done_log.size(), o_error);
        end
    endtask

    task automatic test_timeout_boundary();
        bit to;
        for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
        // Completion on the very last counted cycle is accepted.
        model_run(-1);
        run_seq(T, to);
        n_cmp++;
        if (to || done_log.size() != 1 || o_error !== 1'b0 || got.size() != exp.size()) begin
            n_bad++; $display("FAIL coincident_complete: got done=%0d err=%b strobes=%0d, required done=1 err=0 strobes=%0d",
                              done_log.size(), o_error, got.size(), exp.size());
        end
        // One cycle later the timeout has already fired on the first entry.
        model_run(0);
        run_seq(T + 1, to);
        n_cmp++;
        if (to || done_log.size() != 0 || {o_error, o_err_index} !== {1'b1, 8'd0} || got.size() != 1) begin
            n_bad++; $display("FAIL late_complete: got done=%0d err=%b idx=%0d strobes=%0d, required done=0 err=1 idx=0 strobes=1",
                              done_log.size(), o_error, o_err_index, got.size());
        end
    endtask

    task automatic test_random();
        bit to;
        int d, fail;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
            d = $urandom_range(1, T);
            fail = ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1;
            drop_idx = fail; bad_idx = -1;
`ifdef HDP_SEQ_VERIFY_EN
            if (fail < 0 && $urandom_range(0, 1) == 1) begin
                bad_idx = $urandom_range(0, N - 1);
                bad_val = rom[bad_idx][7:0] ^ 8'h01;
            end
`endif
            model_run(fail);
            run_seq(d, to);
            drop_idx = -1; bad_idx = -1;
            n_cmp++; if (to) begin n_bad++; $display("FAIL random[%0d]_busy: busy stuck high, required idle", it); end
            n_cmp++;
            if (got.size() != exp.size()) begin
                n_bad++; $display("FAIL random[%0d]_strobe_count: got %0d, required %0d", it, got.size(), exp.size());
            end
            for (int i = 0; i < got.size() && i < exp.size(); i++) begin
                n_cmp++;
                if ({got[i].addr, got[i].up, got[i].lo} !== {exp[i].addr, exp[i].up, exp[i].lo}) begin
                    n_bad++; $display("FAIL random[%0d]_strobe[%0d]: got %h/%h/%h, required %h/%h/%h", it,
                                      i, got[i].addr, got[i].up, got[i].lo, exp[i].addr, exp[i].up, exp[i].lo);
                end
            end
            n_cmp++;
            if (done_log.size() != (exp_done ? 1 : 0) || o_error !== !exp_done || (!exp_done && o_err_index !== exp_err)) begin
                n_bad++; $display("FAIL random[%0d]_outcome: got done=%0d err=%b idx=%0d, required done=%0d err=%b idx=%0d", it,
                                  done_log.size(), o_error, o_err_index, exp_done ? 1 : 0, !exp_done, exp_err);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        i_reset = 1'b1; i_start = 1'b0;
        test_reset();
        test_basic_writes();
        test_timeout();
`ifdef HDP_SEQ_VERIFY_EN
        test_verify_mismatch();
`endif
        test_reset_midway();
        test_busy_ignore();
        test_timeout_boundary();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
